history_file_mp: RTL and testbench

- Parametrised successor to the single-port history file. Sits between decode and writeback.
- Records each issued instruction's PC, destination register and pre-write destination value in a circular buffer indexed by tag.
- Accepts tag-addressed completions on WB_PORTS writeback channels and retires up to RETIRE_W entries in order per cycle.
- On the oldest excepting instruction: kills the pipeline, restores register values youngest-to-oldest, then reports mepc/mcause/mtval.

---
 rtl/hf_pkg.sv | 14 +
 rtl/hf_retire_select.sv | 59 +++++
 rtl/history_file_mp.sv | 232 +++++++++++++++++++++++
 tb/tb_history_file_mp.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hf_pkg.sv
// Shared types for the multi-port history file: controller states and the
// "no exception" cause encoding.
package hf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        REPORT  = 2'd2
    } hf_state_e;

    // A completion whose cause equals this value is a clean completion.
    localparam int EXC_NONE = 0;

endpackage

// File: rtl/hf_retire_select.sv
// Combinational retire/exception selector. Views the per-entry flags
// starting at head, counts the run of clean completed entries (capped at
// RETIRE_W and at the occupancy) and flags whether the entry just past that
// run is a completed excepting one.
module hf_retire_select
    import hf_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int RETIRE_W = 2,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] done_i,
    input  logic [DEPTH-1:0] exc_nz_i,
    input  logic [TAG_W-1:0] head_i,
    input  logic [TAG_W:0]   count_i,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic             exc_hit_o,
    output logic [TAG_W-1:0] exc_idx_o
);
    localparam int PTR_W = TAG_W + 1;

    // Bit k of these vectors describes the entry k slots after head.
    logic [DEPTH-1:0] ok_rot;
    logic [DEPTH-1:0] exc_rot;
    logic [CNT_W-1:0] cnt;

    // Rotate the flag vectors so the oldest entry sits at bit 0.
    always_comb begin
        logic [TAG_W-1:0] idx;
        idx     = '0;
        ok_rot  = '0;
        exc_rot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx        = head_i + TAG_W'(k);
            ok_rot[k]  = valid_i[idx] & done_i[idx] & ~exc_nz_i[idx];
            exc_rot[k] = valid_i[idx] & done_i[idx] & exc_nz_i[idx];
        end
    end

    // Count the leading clean run, then test the first entry after it.
    always_comb begin
        logic run;
        run = 1'b1;
        cnt = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (run && ok_rot[k] && (PTR_W'(k) < count_i)) begin
                cnt = cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        retire_cnt_o = cnt;
        exc_idx_o    = head_i + TAG_W'(cnt);
        exc_hit_o    = (PTR_W'(cnt) < count_i) && exc_rot[TAG_W'(cnt)];
    end

endmodule

// File: rtl/history_file_mp.sv
// Multi-port history file. Records issued instructions in a tag-indexed
// circular buffer, accepts out-of-order completions on several writeback
// ports, retires clean entries in order, and on the oldest exception kills
// the pipeline, restores destination registers youngest-first and reports
// the exception CSR values.
module history_file_mp
    import hf_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int XLEN     = 32,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 2,
    parameter int RETIRE_W = 2,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         alloc_valid_i,
    output logic                         alloc_ready_o,
    input  logic [XLEN-1:0]              alloc_pc_i,
    input  logic [REG_W-1:0]             alloc_dest_reg_i,
    input  logic [XLEN-1:0]              alloc_old_value_i,
    output logic [TAG_W-1:0]             alloc_tag_o,
    input  logic [WB_PORTS-1:0]          wb_valid_i,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag_i,
    input  logic [WB_PORTS*XLEN-1:0]     wb_exc_i,
    input  logic [WB_PORTS*XLEN-1:0]     wb_miss_addr_i,
    output logic [$clog2(RETIRE_W+1)-1:0] retire_cnt_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         kill_o,
    output logic [XLEN-1:0]              kill_pc_o,
    output logic                         rec_write_en_o,
    output logic [REG_W-1:0]             rec_dest_reg_o,
    output logic [XLEN-1:0]              rec_value_o,
    output logic                         exc_valid_o,
    output logic [XLEN-1:0]              exc_mepc_o,
    output logic [XLEN-1:0]              exc_mcause_o,
    output logic [XLEN-1:0]              exc_mtval_o
);
    localparam int PTR_W = TAG_W + 1;
    localparam int CNT_W = $clog2(RETIRE_W + 1);

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  old_value;
        logic [XLEN-1:0]  exc;
        logic [XLEN-1:0]  mtval;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    hf_state_e        state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] rec_ptr_q, rec_ptr_d;
    logic [PTR_W-1:0] exc_ptr_q, exc_ptr_d;
    logic [XLEN-1:0]  lat_pc_q, lat_pc_d;
    logic [XLEN-1:0]  lat_cause_q, lat_cause_d;
    logic [XLEN-1:0]  lat_mtval_q, lat_mtval_d;

    logic [PTR_W-1:0] count;
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] done_vec;
    logic [DEPTH-1:0] exc_nz_vec;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_hit;
    logic [TAG_W-1:0] sel_idx;

    assign count         = tail_q - head_q;
    assign full_o        = (tail_q[TAG_W] != head_q[TAG_W]) &&
                           (tail_q[TAG_W-1:0] == head_q[TAG_W-1:0]);
    assign empty_o       = (count == '0);
    assign alloc_ready_o = !full_o && (state_q == IDLE);
    assign alloc_tag_o   = tail_q[TAG_W-1:0];

    // Flatten the registered per-entry flags for the selector.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i]  = entry_q[i].valid;
            done_vec[i]   = entry_q[i].done;
            exc_nz_vec[i] = (entry_q[i].exc != XLEN'(EXC_NONE));
        end
    end

    hf_retire_select #(
        .DEPTH    (DEPTH),
        .RETIRE_W (RETIRE_W),
        .TAG_W    (TAG_W),
        .CNT_W    (CNT_W)
    ) u_select (
        .valid_i      (valid_vec),
        .done_i       (done_vec),
        .exc_nz_i     (exc_nz_vec),
        .head_i       (head_q[TAG_W-1:0]),
        .count_i      (count),
        .retire_cnt_o (sel_cnt),
        .exc_hit_o    (sel_hit),
        .exc_idx_o    (sel_idx)
    );

    // Next-state, buffer updates and outputs for IDLE/RECOVER/REPORT.
    always_comb begin
        logic [TAG_W-1:0] idx;
        logic [TAG_W-1:0] wtag;
        idx         = '0;
        wtag        = '0;
        entry_d     = entry_q;
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        rec_ptr_d   = rec_ptr_q;
        exc_ptr_d   = exc_ptr_q;
        lat_pc_d    = lat_pc_q;
        lat_cause_d = lat_cause_q;
        lat_mtval_d = lat_mtval_q;

        retire_cnt_o   = '0;
        kill_o         = 1'b0;
        kill_pc_o      = '0;
        rec_write_en_o = 1'b0;
        rec_dest_reg_o = '0;
        rec_value_o    = '0;
        exc_valid_o    = 1'b0;
        exc_mepc_o     = '0;
        exc_mcause_o   = '0;
        exc_mtval_o    = '0;

        case (state_q)
            IDLE: begin
                retire_cnt_o = sel_cnt;
                for (int k = 0; k < RETIRE_W; k++) begin
                    if (CNT_W'(k) < sel_cnt) begin
                        idx                = head_q[TAG_W-1:0] + TAG_W'(k);
                        entry_d[idx].valid = 1'b0;
                        entry_d[idx].done  = 1'b0;
                    end
                end
                head_d = head_q + PTR_W'(sel_cnt);

                // Walk ports highest-first so the lowest index lands last.
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    wtag = wb_tag_i[p*TAG_W +: TAG_W];
                    if (wb_valid_i[p] && entry_q[wtag].valid && !entry_q[wtag].done) begin
                        entry_d[wtag].done  = 1'b1;
                        entry_d[wtag].exc   = wb_exc_i[p*XLEN +: XLEN];
                        entry_d[wtag].mtval = wb_miss_addr_i[p*XLEN +: XLEN];
                    end
                end

                if (alloc_valid_i && alloc_ready_o) begin
                    entry_d[alloc_tag_o] = '{valid: 1'b1, done: 1'b0,
                                             pc: alloc_pc_i,
                                             dest: alloc_dest_reg_i,
                                             old_value: alloc_old_value_i,
                                             exc: '0, mtval: '0};
                    tail_d = tail_q + PTR_W'(1);
                end

                // An allocation accepted in the kill cycle is rolled back too.
                if (sel_hit) begin
                    kill_o      = 1'b1;
                    kill_pc_o   = entry_q[sel_idx].pc;
                    lat_pc_d    = entry_q[sel_idx].pc;
                    lat_cause_d = entry_q[sel_idx].exc;
                    lat_mtval_d = entry_q[sel_idx].mtval;
                    exc_ptr_d   = head_q + PTR_W'(sel_cnt);
                    rec_ptr_d   = tail_d - PTR_W'(1);
                    state_d     = RECOVER;
                end
            end

            RECOVER: begin
                idx                = rec_ptr_q[TAG_W-1:0];
                rec_write_en_o     = (entry_q[idx].dest != '0);
                rec_dest_reg_o     = entry_q[idx].dest;
                rec_value_o        = entry_q[idx].old_value;
                entry_d[idx].valid = 1'b0;
                entry_d[idx].done  = 1'b0;
                if (rec_ptr_q == exc_ptr_q) begin
                    state_d = REPORT;
                end else begin
                    rec_ptr_d = rec_ptr_q - PTR_W'(1);
                end
            end

            REPORT: begin
                exc_valid_o  = 1'b1;
                exc_mepc_o   = lat_pc_q;
                exc_mcause_o = lat_cause_q;
                exc_mtval_o  = lat_mtval_q;
                tail_d       = exc_ptr_q;
                state_d      = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Register state; reset touches control (pointers, flags, FSM) only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
                entry_q[i].done  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Exception bookkeeping; only meaningful outside IDLE.
    always_ff @(posedge clk_i) begin
        rec_ptr_q   <= rec_ptr_d;
        exc_ptr_q   <= exc_ptr_d;
        lat_pc_q    <= lat_pc_d;
        lat_cause_q <= lat_cause_d;
        lat_mtval_q <= lat_mtval_d;
    end

endmodule

// File: tb/tb_history_file_mp.sv
// Self-checking bench for history_file_mp: directed scenarios plus a
// randomized clean-completion phase against a queue-based reference model.
module tb_history_file_mp;
    localparam int DEPTH    = 16;
    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int WB_PORTS = 2;
    localparam int RETIRE_W = 2;
    localparam int TAG_W    = 4;
    localparam int CNT_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      alloc_valid;
    logic                      alloc_ready;
    logic [XLEN-1:0]           alloc_pc;
    logic [REG_W-1:0]          alloc_dest;
    logic [XLEN-1:0]           alloc_old;
    logic [TAG_W-1:0]          alloc_tag;
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*TAG_W-1:0] wb_tag;
    logic [WB_PORTS*XLEN-1:0]  wb_exc;
    logic [WB_PORTS*XLEN-1:0]  wb_miss;
    logic [CNT_W-1:0]          retire_cnt;
    logic                      empty, full, kill;
    logic [XLEN-1:0]           kill_pc;
    logic                      rec_we;
    logic [REG_W-1:0]          rec_dest;
    logic [XLEN-1:0]           rec_value;
    logic                      exc_valid;
    logic [XLEN-1:0]           exc_mepc, exc_mcause, exc_mtval;

    history_file_mp #(
        .DEPTH(DEPTH), .XLEN(XLEN), .REG_W(REG_W),
        .WB_PORTS(WB_PORTS), .RETIRE_W(RETIRE_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_pc_i(alloc_pc), .alloc_dest_reg_i(alloc_dest),
        .alloc_old_value_i(alloc_old), .alloc_tag_o(alloc_tag),
        .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_exc_i(wb_exc),
        .wb_miss_addr_i(wb_miss), .retire_cnt_o(retire_cnt),
        .empty_o(empty), .full_o(full), .kill_o(kill), .kill_pc_o(kill_pc),
        .rec_write_en_o(rec_we), .rec_dest_reg_o(rec_dest),
        .rec_value_o(rec_value), .exc_valid_o(exc_valid),
        .exc_mepc_o(exc_mepc), .exc_mcause_o(exc_mcause), .exc_mtval_o(exc_mtval)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_in();
        alloc_valid = 1'b0;
        alloc_pc    = '0;
        alloc_dest  = '0;
        alloc_old   = '0;
        wb_valid    = '0;
        wb_tag      = '0;
        wb_exc      = '0;
        wb_miss     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wb_set(input int p, input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] e, input logic [XLEN-1:0] m);
        wb_valid[p]               = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]  = t;
        wb_exc[p*XLEN +: XLEN]    = e;
        wb_miss[p*XLEN +: XLEN]   = m;
    endtask

    task automatic alloc_one(input logic [XLEN-1:0] pc, input logic [REG_W-1:0] d,
                             input logic [XLEN-1:0] old);
        alloc_valid = 1'b1;
        alloc_pc    = pc;
        alloc_dest  = d;
        alloc_old   = old;
        tick();
        idle_in();
    endtask

    task automatic check_reset_outs(input string pfx);
        check_eq({pfx, "_ready"},  64'(alloc_ready), 64'd1);
        check_eq({pfx, "_empty"},  64'(empty), 64'd1);
        check_eq({pfx, "_full"},   64'(full), 64'd0);
        check_eq({pfx, "_tag"},    64'(alloc_tag), 64'd0);
        check_eq({pfx, "_retire"}, 64'(retire_cnt), 64'd0);
        check_eq({pfx, "_kill"},   64'(kill), 64'd0);
        check_eq({pfx, "_killpc"}, 64'(kill_pc), 64'd0);
        check_eq({pfx, "_recwe"},  64'(rec_we), 64'd0);
        check_eq({pfx, "_recval"}, 64'(rec_value), 64'd0);
        check_eq({pfx, "_excv"},   64'(exc_valid), 64'd0);
        check_eq({pfx, "_mepc"},   64'(exc_mepc), 64'd0);
    endtask

    // The three pulse outputs must be mutually exclusive every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check_eq("pulse_excl", 64'($countones({kill, rec_we, exc_valid}) <= 1), 64'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q_tag[$];
        bit q_done[$];
        int nt, er, pa, t;
        bit av, pre_full;
        int vtag [WB_PORTS];
        bit vv [WB_PORTS];

        rst = 1'b1;
        idle_in();

        // Test 1: reset values and filling to full.
        do_reset();
        settle();
        check_reset_outs("rst");
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h100 + 32'(i * 4);
            alloc_dest  = REG_W'(i + 1);
            alloc_old   = 32'(i);
            settle();
            check_eq("t1_tag", 64'(alloc_tag), 64'(i));
            check_eq("t1_ready", 64'(alloc_ready), 64'd1);
            tick();
        end
        settle();
        check_eq("t1_full", 64'(full), 64'd1);
        check_eq("t1_ready17", 64'(alloc_ready), 64'd0);
        check_eq("t1_empty", 64'(empty), 64'd0);
        tick();
        idle_in();
        settle();
        check_eq("t1_full_hold", 64'(full), 64'd1);
        check_eq("t1_tag_wrap", 64'(alloc_tag), 64'd0);

        // Test 2: out-of-order completion, in-order retirement.
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(32'h200 + 32'(i * 4), REG_W'(i + 1), 32'(i));
        wb_set(0, 3, 0, 0);
        wb_set(1, 1, 0, 0);
        settle();
        check_eq("t2_ret_a", 64'(retire_cnt), 64'd0);
        tick();
        idle_in();
        wb_set(0, 0, 0, 0);
        wb_set(1, 2, 0, 0);
        settle();
        check_eq("t2_ret_b", 64'(retire_cnt), 64'd0);
        tick();
        idle_in();
        settle();
        check_eq("t2_ret_c", 64'(retire_cnt), 64'd2);
        tick();
        settle();
        check_eq("t2_ret_d", 64'(retire_cnt), 64'd2);
        tick();
        settle();
        check_eq("t2_empty", 64'(empty), 64'd1);
        check_eq("t2_ret_e", 64'(retire_cnt), 64'd0);

        // Test 3: steady one-in/one-out with tag wrap.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h300 + 32'(i * 4);
            alloc_dest  = 5'd7;
            settle();
            check_eq("t3_tag", 64'(alloc_tag), 64'(i % DEPTH));
            check_eq("t3_ret", 64'(retire_cnt), 64'((i > 0) ? 1 : 0));
            check_eq("t3_full", 64'(full), 64'd0);
            tick();
            idle_in();
            wb_set(0, TAG_W'(i % DEPTH), 0, 0);
            settle();
            check_eq("t3_ret_wb", 64'(retire_cnt), 64'd0);
            check_eq("t3_nonempty", 64'(empty), 64'd0);
            tick();
            idle_in();
        end
        settle();
        check_eq("t3_ret_last", 64'(retire_cnt), 64'd1);
        tick();
        settle();
        check_eq("t3_empty", 64'(empty), 64'd1);

        // Test 4: exception on tag 2, recovery and report.
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(32'h1000 + 32'(i * 4), REG_W'(i + 1), 32'hA0 + 32'(i));
        wb_set(0, 2, 32'h5, 32'hDEAD);
        settle();
        check_eq("t4_kill_a", 64'(kill), 64'd0);
        tick();
        idle_in();
        wb_set(0, 0, 0, 0);
        wb_set(1, 1, 0, 0);
        settle();
        check_eq("t4_ret_b", 64'(retire_cnt), 64'd0);
        check_eq("t4_kill_b", 64'(kill), 64'd0);
        tick();
        idle_in();
        settle();
        check_eq("t4_ret_kill", 64'(retire_cnt), 64'd2);
        check_eq("t4_kill", 64'(kill), 64'd1);
        check_eq("t4_kill_pc", 64'(kill_pc), 64'h1008);
        tick();
        for (int r = 0; r < 3; r++) begin
            settle();
            check_eq("t4_rec_we", 64'(rec_we), 64'd1);
            check_eq("t4_rec_dest", 64'(rec_dest), 64'(5 - r));
            check_eq("t4_rec_val", 64'(rec_value), 64'(32'hA4 - 32'(r)));
            check_eq("t4_rec_excv", 64'(exc_valid), 64'd0);
            tick();
        end
        settle();
        check_eq("t4_excv", 64'(exc_valid), 64'd1);
        check_eq("t4_mepc", 64'(exc_mepc), 64'h1008);
        check_eq("t4_mcause", 64'(exc_mcause), 64'h5);
        check_eq("t4_mtval", 64'(exc_mtval), 64'hDEAD);
        check_eq("t4_rep_we", 64'(rec_we), 64'd0);
        tick();
        settle();
        check_eq("t4_empty", 64'(empty), 64'd1);
        check_eq("t4_excv_off", 64'(exc_valid), 64'd0);
        check_eq("t4_ready", 64'(alloc_ready), 64'd1);
        check_eq("t4_tag", 64'(alloc_tag), 64'd2);

        // Test 5: same tag on both ports, lowest port wins.
        do_reset();
        alloc_one(32'h500, 5'd1, 32'h1);
        alloc_one(32'h504, 5'd2, 32'h2);
        wb_set(0, 1, 0, 0);
        wb_set(1, 1, 32'h2, 32'hBEEF);
        tick();
        idle_in();
        wb_set(0, 0, 0, 0);
        settle();
        check_eq("t5_ret_a", 64'(retire_cnt), 64'd0);
        check_eq("t5_kill_a", 64'(kill), 64'd0);
        tick();
        idle_in();
        settle();
        check_eq("t5_ret", 64'(retire_cnt), 64'd2);
        check_eq("t5_kill", 64'(kill), 64'd0);
        tick();
        settle();
        check_eq("t5_empty", 64'(empty), 64'd1);

        // Test 6: reset asserted during the second recovery cycle.
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(32'h600 + 32'(i * 4), REG_W'(i + 1), 32'hB0 + 32'(i));
        wb_set(0, 0, 32'h7, 32'h77);
        tick();
        idle_in();
        settle();
        check_eq("t6_kill", 64'(kill), 64'd1);
        check_eq("t6_kill_pc", 64'(kill_pc), 64'h600);
        tick();
        settle();
        check_eq("t6_rec1_dest", 64'(rec_dest), 64'd3);
        tick();
        rst = 1'b1;
        settle();
        check_eq("t6_rec2_dest", 64'(rec_dest), 64'd2);
        tick();
        rst = 1'b0;
        settle();
        check_reset_outs("t6");
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            check_eq("t6_no_report", 64'(exc_valid), 64'd0);
            check_eq("t6_empty", 64'(empty), 64'd1);
        end

        // Randomized clean-completion phase against a queue model.
        do_reset();
        nt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            pa = ((cyc % 200) < 100) ? 7 : 3;
            idle_in();
            av          = ($urandom_range(0, 9) < pa);
            alloc_valid = av;
            alloc_pc    = $urandom;
            alloc_dest  = REG_W'($urandom_range(0, 31));
            alloc_old   = $urandom;
            for (int p = 0; p < WB_PORTS; p++) begin
                vv[p]   = ($urandom_range(0, 9) < (10 - pa));
                vtag[p] = 0;
                if (vv[p]) begin
                    if (q_tag.size() > 0 && $urandom_range(0, 3) != 0)
                        t = q_tag[$urandom_range(0, q_tag.size() - 1)];
                    else
                        t = $urandom_range(0, DEPTH - 1);
                    vtag[p] = t;
                    wb_set(p, TAG_W'(t), 0, $urandom);
                end
            end
            settle();

            er = 0;
            while (er < RETIRE_W && er < q_tag.size() && q_done[er]) er++;
            pre_full = (q_tag.size() == DEPTH);
            check_eq("rnd_retire", 64'(retire_cnt), 64'(er));
            check_eq("rnd_empty", 64'(empty), 64'(q_tag.size() == 0));
            check_eq("rnd_full", 64'(full), 64'(pre_full));
            check_eq("rnd_ready", 64'(alloc_ready), 64'(!pre_full));
            check_eq("rnd_tag", 64'(alloc_tag), 64'(nt));
            check_eq("rnd_kill", 64'(kill), 64'd0);

            for (int p = 0; p < WB_PORTS; p++) begin
                if (vv[p]) begin
                    for (int j = 0; j < q_tag.size(); j++) begin
                        if (q_tag[j] == vtag[p] && !q_done[j]) q_done[j] = 1'b1;
                    end
                end
            end
            repeat (er) begin
                void'(q_tag.pop_front());
                void'(q_done.pop_front());
            end
            if (av && !pre_full) begin
                q_tag.push_back(nt);
                q_done.push_back(1'b0);
                nt = (nt + 1) % DEPTH;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
